// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO pair for the E stage.
// Results are computed on acceptance and committed to HI/LO when the busy period ends.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        md_wait,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
  logic        pend_wr_q, pend_wr_d;

  logic        done, can_start, md_op;
  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic [31:0] div_a, div_b, div_b_safe, q_mag, r_mag, quot, rem;

  assign done      = (state_q == StRun) && (cnt_q == 32'd1);
  // The completing edge doubles as an idle edge so back-to-back operations lose no cycle.
  assign can_start = (state_q == StIdle) || done;
  assign md_op     = ~op[2];

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed division on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign div_signed = ~op[0];
  assign div_a      = (div_signed && A[31]) ? -A : A;
  assign div_b      = (div_signed && B[31]) ? -B : B;
  assign div_b_safe = (div_b == 32'd0) ? 32'd1 : div_b;
  assign q_mag      = div_a / div_b_safe;
  assign r_mag      = div_a % div_b_safe;
  assign quot       = (div_signed && (A[31] ^ B[31])) ? -q_mag : q_mag;
  assign rem        = (div_signed && A[31]) ? -r_mag : r_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (can_start && start && md_op) begin
      state_d = StRun;
    end else if (done) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    busy    = (state_q == StRun);
    md_wait = busy | (start & md_op);
    HI      = hi_q;
    LO      = lo_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    pend_wr_d = pend_wr_q;
    if (state_q == StRun) begin
      cnt_d = cnt_q - 32'd1;
    end
    if (done && pend_wr_q) begin
      hi_d = hi_pend_q;
      lo_d = lo_pend_q;
    end
    if (can_start && start) begin
      case (op)
        3'd0: begin
          {hi_pend_d, lo_pend_d} = prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_CYCLES;
        end
        3'd1: begin
          {hi_pend_d, lo_pend_d} = prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = MULT_CYCLES;
        end
        3'd2, 3'd3: begin
          hi_pend_d = rem;
          lo_pend_d = quot;
          pend_wr_d = (B != 32'd0);
          cnt_d     = DIV_CYCLES;
        end
        3'd4:    hi_d = A;
        3'd5:    lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      hi_pend_q <= 32'd0;
      lo_pend_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      pend_wr_q <= pend_wr_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, compared when busy drops.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy, md_wait;
  logic [31:0] HI, LO;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .md_wait (md_wait),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint p;
    int q, r;
    case (o)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return cur;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {r, q};
      end
      3'd3: begin
        if (b == 32'd0) return cur;
        return {a % b, a / b};
      end
      default: return cur;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1 start = 1'b0;
    if (o < 3'd4) exp_q.push_back(model(o, a, b, {m_hi, m_lo}));
    else if (o == 3'd4) m_hi = a;
    else if (o == 3'd5) m_lo = a;
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty got=0 exp=1", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_hi"}, HI, e[63:32]);
    check({tag, "_lo"}, LO, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  // Counts negedges with busy high after the issue edge, bounded.
  task automatic wait_done(input string tag, input int n);
    int cyc = 0;
    @(negedge clk);
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, cyc, n);
    pop_check(tag);
  endtask

  initial begin
    // Reset state; md_wait stays combinational during reset
    start = 1'b1; op = 3'd2;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_md_wait", {31'd0, md_wait}, 32'd1);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Reset mid-run: pending result discarded
    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk); @(posedge clk);
    #2;
    check("midrun_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("midrun_busy", {31'd0, busy}, 32'd0);
    check("midrun_hi", HI, 32'd0);
    check("midrun_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("midrun_after_busy", {31'd0, busy}, 32'd0);
    check("midrun_after_lo", LO, 32'd0);

    // Multiply
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done("mult", 5);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_done("multu", 5);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_big", 5);

    // Divide
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 10);
    issue(3'd3, 32'd7, 32'd2);
    wait_done("divu", 10);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 10);
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_negdiv", 10);

    // MTHI/MTLO then divide by zero
    issue(3'd4, 32'h1234, 32'd0);
    check("mthi", HI, m_hi);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd5, 32'h5678, 32'd0);
    check("mtlo", LO, m_lo);
    issue(3'd2, 32'd9, 32'd0);
    wait_done("div0", 10);

    // No-op leaves state alone
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    check("nop_hi", HI, m_hi);
    check("nop_busy", {31'd0, busy}, 32'd0);

    // Overlap: MTHI while a divide is in flight is ignored
    issue(3'd2, 32'd100, 32'd7);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd4; A = 32'hAAAA;
    @(posedge clk);
    #1 start = 1'b0;
    check("overlap_hi_hold", HI, m_hi);
    wait_done("overlap", 8);

    // Back-to-back: MULT presented on the edge busy falls
    issue(3'd3, 32'd20, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("b2b_busy_pre", {31'd0, busy}, 32'd1);
    start = 1'b1; op = 3'd0; A = 32'd2; B = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    exp_q.push_back(model(3'd0, 32'd2, 32'd5, 64'd0));
    check("b2b_busy_cont", {31'd0, busy}, 32'd1);
    pop_check("b2b_div");
    wait_done("b2b_mult", 5);

    // md_wait in IDLE
    @(negedge clk);
    start = 1'b1; op = 3'd2;
    #1;
    check("mdw_div", {31'd0, md_wait}, 32'd1);
    check("mdw_div_busy", {31'd0, busy}, 32'd0);
    op = 3'd5;
    #1;
    check("mdw_mtlo", {31'd0, md_wait}, 32'd0);
    op = 3'd6;
    #1;
    check("mdw_nop", {31'd0, md_wait}, 32'd0);
    start = 1'b0;
    op = 3'd0;
    #1;
    check("mdw_nostart", {31'd0, md_wait}, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
